// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle shared by the scanner and whatever sits on the
// board side (pins, bench model) or consumes the decoded key events.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_release;
    logic       key_held;

    modport master (
        input  row,
        output col, key_code, key_valid, key_release, key_held
    );

    modport slave (
        output row,
        input  col, key_code, key_valid, key_release, key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, assembles a full
// scan, classifies it and debounces presses/releases into one-cycle key events.
module keypad_scanner #(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  kp
);

    localparam int DW = $clog2(SCAN_TICKS);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    // Hex legend indexed by {row, col}; nibble 0 is the top-left key.
    localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_kind_t;
    typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, RELEASE_PEND} state_t;

    logic [3:0]    row_meta, row_sync;
    logic [DW-1:0] dwell_q;
    logic [1:0]    column_q;
    logic [15:0]   scan_vec_q;
    logic          last_tick;

    // NOTE: every flop uses <= so all registers sample pre-edge values together;
    // a blocking = here would let later statements see this edge's new values.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= kp.row;
            row_sync <= row_meta;
        end
    end

    assign last_tick = (dwell_q == DW'(SCAN_TICKS - 1));

    // NOTE: the scan vector is plain flops, not RAM, so it can and must be reset
    // to all ones; otherwise the first scan after reset could see phantom keys.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q    <= '0;
            column_q   <= '0;
            scan_vec_q <= '1;
        end else if (last_tick) begin
            dwell_q                        <= '0;
            column_q                       <= column_q + 2'd1;
            scan_vec_q[{column_q, 2'b00} +: 4] <= row_sync;
        end else begin
            dwell_q <= dwell_q + DW'(1);
        end
    end

    // Classification sees column 3 straight from the synchronizer so the result
    // can be registered on the same edge that would capture it.
    logic [15:0] full_vec;
    logic [1:0]  zero_cnt;
    logic [3:0]  zero_pos;

    assign full_vec = {row_sync, scan_vec_q[11:0]};

    // NOTE: outputs of always_comb get a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        zero_cnt = 2'd0;
        zero_pos = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!full_vec[i]) begin
                zero_cnt = (zero_cnt == 2'd0) ? 2'd1 : 2'd2;
                zero_pos = 4'(i);
            end
        end
    end

    res_kind_t  res_kind_q;
    logic [3:0] res_key_q;
    logic       res_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_kind_q  <= RES_NONE;
            res_key_q   <= '0;
            res_valid_q <= 1'b0;
        end else begin
            res_valid_q <= last_tick && (column_q == 2'd3);
            if (last_tick && (column_q == 2'd3)) begin
                res_kind_q <= (zero_cnt == 2'd0) ? RES_NONE :
                              (zero_cnt == 2'd1) ? RES_KEY  : RES_MULTI;
                // Scan bit position is col*4+row; the legend is indexed by {row, col}.
                res_key_q  <= KEY_MAP[{zero_pos[1:0], zero_pos[3:2], 2'b00} +: 4];
            end
        end
    end

    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    code_q, code_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          valid_q, valid_d;
    logic          release_q, release_d;
    logic          is_key;

    assign is_key  = (res_kind_q == RES_KEY);
    assign cnt_inc = (cnt_q == CW'(DEBOUNCE_SCANS)) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cand_q    <= '0;
            code_q    <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        code_d    = code_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        release_d = 1'b0;
        if (res_valid_q) begin
            unique case (state_q)
                IDLE: begin
                    if (is_key) begin
                        state_d = PRESS_PEND;
                        cand_d  = res_key_q;
                        cnt_d   = CW'(1);
                    end
                end
                PRESS_PEND: begin
                    if (is_key && res_key_q == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
                            state_d = HELD;
                            code_d  = cand_q;
                            valid_d = 1'b1;
                        end
                    end else if (is_key) begin
                        cand_d = res_key_q;
                        cnt_d  = CW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (!(is_key && res_key_q == code_q)) begin
                        state_d = RELEASE_PEND;
                        cnt_d   = CW'(1);
                    end
                end
                RELEASE_PEND: begin
                    if (is_key && res_key_q == code_q) begin
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
                            state_d   = IDLE;
                            release_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign kp.col         = ~(4'b0001 << column_q);
    assign kp.key_code    = code_q;
    assign kp.key_valid   = valid_q;
    assign kp.key_release = release_q;
    assign kp.key_held    = (state_q == HELD) || (state_q == RELEASE_PEND);

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: stimulus queues expected key events from
// a key-level model, an independent monitor pops them as pulses appear.
module tb_keypad_scanner;

    localparam int ST    = 8;
    localparam int DS    = 3;
    localparam int SCAN  = 4 * ST;
    localparam int BOUND = (DS + 1) * SCAN + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keypad_scanner_if kp();

    keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DS)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    // Pressed keys, bit r*4+c; the matrix pulls row r low while col c is low.
    logic [15:0] pressed = '0;

    always_comb begin
        kp.row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kp.col[c]) kp.row[r] = 1'b0;
    end

    logic [3:0] hex_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'h0, 4'hF, 4'hE, 4'hD};

    typedef struct {
        bit         rel;
        logic [3:0] code;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (kp.key_valid || kp.key_release) begin
            if (rst) begin
                check("pulse_during_reset", {30'd0, kp.key_valid, kp.key_release}, 32'd0);
            end else if (kp.key_valid && kp.key_release) begin
                check("valid_and_release_together", 32'(kp.key_release), 32'd0);
            end else if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: valid=%b release=%b code=%h, no event expected (t=%0t)",
                         kp.key_valid, kp.key_release, kp.key_code, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind_release", 32'(kp.key_release), 32'(e.rel));
                check("key_code", 32'(kp.key_code), 32'(e.code));
                check("key_held_at_pulse", 32'(kp.key_held), 32'(!e.rel));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_event(input bit rel, input int k);
        exp_t e;
        e.rel  = rel;
        e.code = hex_map[k];
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Waits for the column strobe to wrap back to column 0 (just after a full scan).
    task automatic wait_scan_start();
        logic [3:0] prev;
        int n;
        prev = kp.col;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (kp.col == 4'b1110 && prev != 4'b1110) break;
            prev = kp.col;
        end while (n < 2 * SCAN);
        check("scan_wrap_seen", 32'(kp.col == 4'b1110 && n < 2 * SCAN), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"},         32'(kp.col), 32'h0000000E);
        check({tag, "_key_code"},    32'(kp.key_code), 32'd0);
        check({tag, "_key_valid"},   32'(kp.key_valid), 32'd0);
        check({tag, "_key_release"}, 32'(kp.key_release), 32'd0);
        check({tag, "_key_held"},    32'(kp.key_held), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_col;
        int k;

        // Reset and idle column walk
        rst = 1'b1;
        cycles(5);
        check_reset_outputs("reset");
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            exp_col = ~(4'b0001 << ((i / ST) % 4));
            check("col_sequence", 32'(kp.col), 32'(exp_col));
            @(negedge clk);
        end
        check("idle_key_code", 32'(kp.key_code), 32'd0);
        check("idle_key_held", 32'(kp.key_held), 32'd0);

        // Single press of (r1,c2)
        pressed[6] = 1'b1;
        expect_event(1'b0, 6);
        drain("press_latency", BOUND);
        check("held_after_press", 32'(kp.key_held), 32'd1);
        pressed[6] = 1'b0;
        expect_event(1'b1, 6);
        drain("release_latency", BOUND);
        check("held_after_release", 32'(kp.key_held), 32'd0);
        check("code_kept_after_release", 32'(kp.key_code), 32'h6);

        // Bounce on (r3,c1): no scan window ever sees three matching scans
        for (int t = 0; t < 300; t += 40) begin
            pressed[13] = ~pressed[13];
            cycles(40);
        end
        pressed[13] = 1'b1;
        expect_event(1'b0, 13);
        drain("bounce_press", BOUND);
        pressed[13] = 1'b0;
        expect_event(1'b1, 13);
        drain("bounce_release", BOUND);

        // Two keys together are ignored until one lifts
        pressed[0]  = 1'b1;
        pressed[11] = 1'b1;
        cycles(6 * SCAN);
        pressed[11] = 1'b0;
        expect_event(1'b0, 0);
        drain("multi_then_single", BOUND);
        pressed[0] = 1'b0;
        expect_event(1'b1, 0);
        drain("multi_release", BOUND);

        // One-scan dropout while (r0,c3) is held
        pressed[3] = 1'b1;
        expect_event(1'b0, 3);
        drain("glitch_press", BOUND);
        cycles(2 * SCAN);
        wait_scan_start();
        pressed[3] = 1'b0;
        wait_scan_start();
        pressed[3] = 1'b1;
        cycles(5 * SCAN);
        check("glitch_held", 32'(kp.key_held), 32'd1);
        check("glitch_code", 32'(kp.key_code), 32'hA);
        pressed[3] = 1'b0;
        expect_event(1'b1, 3);
        drain("glitch_release", BOUND);

        // Randomized press/release of single keys with random dwell
        for (int it = 0; it < 10; it++) begin
            k = int'($urandom_range(0, 15));
            cycles(int'($urandom_range(0, 30)));
            pressed[k] = 1'b1;
            expect_event(1'b0, k);
            drain("rand_press", BOUND);
            cycles(int'($urandom_range(0, 60)));
            pressed[k] = 1'b0;
            expect_event(1'b1, k);
            drain("rand_release", BOUND);
        end

        // Reset after two matching scans of (r2,c0) discards the debounce count
        wait_scan_start();
        pressed[8] = 1'b1;
        wait_scan_start();
        wait_scan_start();
        cycles(2);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_debounce_reset");
        cycles(3);
        rst = 1'b0;
        expect_event(1'b0, 8);
        cycles(80);
        check("no_early_accept_after_reset", 32'(exp_q.size()), 32'd1);
        drain("press_after_reset", BOUND);
        pressed[8] = 1'b0;
        expect_event(1'b1, 8);
        drain("release_after_reset", BOUND);

        cycles(2 * SCAN);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
